// File: rtl/alu_matrix_pkg.sv
// Shared constants for the 3x3 matrix ALU: default element width, matrix
// dimension and the named command/selector codes carried on sel.
package alu_matrix_pkg;

    localparam int DATA_W = 32;
    localparam int DIM    = 3;
    localparam int N_ELEM = DIM * DIM;

    localparam logic [5:0] LOAD_A_BASE = 6'd0;
    localparam logic [5:0] LOAD_B_BASE = 6'd9;
    localparam logic [5:0] READ_R_BASE = 6'd18;
    localparam logic [5:0] READ_D      = 6'd27;
    localparam logic [5:0] TRANSPOSE   = 6'd28;
    localparam logic [5:0] ADD         = 6'd29;
    localparam logic [5:0] SUB         = 6'd30;
    localparam logic [5:0] MUL         = 6'd31;
    localparam logic [5:0] SCALE       = 6'd32;
    localparam logic [5:0] DET         = 6'd33;

    // Row-major flat index of element (row, col).
    function automatic int elem_idx(input int row, input int col);
        return DIM * row + col;
    endfunction

endpackage

// File: rtl/matrix_det3.sv
// Combinational 3x3 determinant by cofactor expansion along the first row.
// Elements m[0..8] are row-major: a b c / d e f / g h i. Result wraps to
// DATA_W bits (two's complement).
module matrix_det3 #(
    parameter int DATA_W = 32
) (
    input  logic [DATA_W-1:0] m [9],
    output logic [DATA_W-1:0] det
);

    // a(ei - fh) - b(di - fg) + c(dh - eg), all arithmetic modulo 2^DATA_W
    always_comb begin
        det = m[0] * (m[4] * m[8] - m[5] * m[7])
            - m[1] * (m[3] * m[8] - m[5] * m[6])
            + m[2] * (m[3] * m[7] - m[4] * m[6]);
    end

endmodule

// File: rtl/alu_matrix_top.sv
// 3x3 register-matrix ALU. Operand matrices A and B are loaded one element
// per cycle, single-cycle commands write the result matrix R, and R or the
// scalar D is read back through a registered eleOut.
// Optional feature: define ALU_MATRIX_DET_EN to enable the determinant
// command (sel 33) into D; without it sel 33 is a no-op and D reads as 0.
module alu_matrix_top
    import alu_matrix_pkg::*;
#(
    parameter int DATA_W = alu_matrix_pkg::DATA_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [5:0]        sel,
    input  logic [DATA_W-1:0] eleIn,
    output logic [DATA_W-1:0] eleOut
);

    logic [DATA_W-1:0] a_m    [N_ELEM];
    logic [DATA_W-1:0] b_m    [N_ELEM];
    logic [DATA_W-1:0] r_m    [N_ELEM];
    logic [DATA_W-1:0] r_next [N_ELEM];
    logic [DATA_W-1:0] acc;
    logic [DATA_W-1:0] d_val;
    logic              r_we;

    // Next value of R for whichever matrix command is on sel this cycle
    always_comb begin
        // NOTE: every output gets a default first so no path can infer a latch.
        r_we = 1'b1;
        acc  = '0;
        for (int i = 0; i < N_ELEM; i++) r_next[i] = '0;
        case (sel)
            TRANSPOSE: begin
                for (int r = 0; r < DIM; r++)
                    for (int c = 0; c < DIM; c++)
                        r_next[elem_idx(r, c)] = a_m[elem_idx(c, r)];
            end
            ADD: for (int i = 0; i < N_ELEM; i++) r_next[i] = a_m[i] + b_m[i];
            SUB: for (int i = 0; i < N_ELEM; i++) r_next[i] = a_m[i] - b_m[i];
            MUL: begin
                for (int r = 0; r < DIM; r++) begin
                    for (int c = 0; c < DIM; c++) begin
                        acc = '0;
                        for (int k = 0; k < DIM; k++)
                            acc = acc + a_m[elem_idx(r, k)] * b_m[elem_idx(k, c)];
                        r_next[elem_idx(r, c)] = acc;
                    end
                end
            end
            SCALE: for (int i = 0; i < N_ELEM; i++) r_next[i] = eleIn * a_m[i];
            default: r_we = 1'b0;
        endcase
    end

    // Element loads, result update and registered read-back
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            // NOTE: the matrices are plain flops rather than RAM, so they can
            // and must be cleared by the asynchronous reset.
            for (int i = 0; i < N_ELEM; i++) begin
                a_m[i] <= '0;
                b_m[i] <= '0;
                r_m[i] <= '0;
            end
            eleOut <= '0;
        end else begin
            // NOTE: non-blocking so every command sees the pre-edge register values.
            for (int i = 0; i < N_ELEM; i++) begin
                if (sel == 6'(LOAD_A_BASE + i)) a_m[i] <= eleIn;
                if (sel == 6'(LOAD_B_BASE + i)) b_m[i] <= eleIn;
                if (sel == 6'(READ_R_BASE + i)) eleOut <= r_m[i];
                if (r_we) r_m[i] <= r_next[i];
            end
            if (sel == READ_D) eleOut <= d_val;
        end
    end

`ifdef ALU_MATRIX_DET_EN
    logic [DATA_W-1:0] det_val;

    matrix_det3 #(.DATA_W(DATA_W)) u_det (
        .m   (a_m),
        .det (det_val)
    );

    // Scalar D captures the determinant of A on the DET command
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            d_val <= '0;
        else if (sel == DET)
            d_val <= det_val;
    end
`else
    assign d_val = '0;
`endif

endmodule

// File: tb/tb_alu_matrix_top.sv
// Directed self-checking bench for alu_matrix_top: load/transpose, add,
// subtract, multiply, scale, no-op hold, determinant, async reset and
// wrap-around. Expected values are hand-computed constants.
module tb_alu_matrix_top;

    localparam int DATA_W = 32;

    logic              clk;
    logic              reset;
    logic [5:0]        sel;
    logic [DATA_W-1:0] eleIn;
    logic [DATA_W-1:0] eleOut;

    int errors = 0;
    int checks = 0;

    alu_matrix_top #(.DATA_W(DATA_W)) dut (
        .clk    (clk),
        .reset  (reset),
        .sel    (sel),
        .eleIn  (eleIn),
        .eleOut (eleOut)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [DATA_W-1:0] got,
                         input logic [DATA_W-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Apply one command for one rising edge, then settle just after it.
    task automatic step(input logic [5:0] s, input logic [DATA_W-1:0] d);
        sel   = s;
        eleIn = d;
        @(posedge clk);
        #1;
    endtask

    task automatic read_r(input string tag, input int exp [9]);
        for (int i = 0; i < 9; i++) begin
            step(6'(18 + i), '0);
            check($sformatf("%s[%0d]", tag, i), eleOut, DATA_W'(exp[i]));
        end
    endtask

    int exp_t    [9] = '{0, 3, 6, 1, 4, 7, 2, 5, 8};
    int exp_2x   [9] = '{0, 2, 4, 6, 8, 10, 12, 14, 16};
    int exp_zero [9] = '{0, 0, 0, 0, 0, 0, 0, 0, 0};
    int exp_mul  [9] = '{15, 18, 21, 42, 54, 66, 69, 90, 111};
    int diag     [9] = '{2, 0, 0, 0, 3, 0, 0, 0, 4};
    logic [DATA_W-1:0] exp_det_diag;

    initial begin
`ifdef ALU_MATRIX_DET_EN
        exp_det_diag = 32'd24;
`else
        exp_det_diag = 32'd0;
`endif
        reset = 1'b1;
        sel   = 6'd0;
        eleIn = 32'd77;
        #2;
        check("reset_eleout", eleOut, 32'd0);
        // sel=0 with data during reset must be ignored
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;
        step(6'd28, '0);
        step(6'd18, '0);
        check("reset_ignores_sel", eleOut, 32'd0);

        // Load A = B = 0..8
        for (int i = 0; i < 9; i++) step(6'(i), DATA_W'(i));
        for (int i = 0; i < 9; i++) step(6'(9 + i), DATA_W'(i));

        step(6'd28, '0);
        read_r("transpose", exp_t);
        step(6'd29, '0);
        read_r("add", exp_2x);
        step(6'd30, '0);
        read_r("sub", exp_zero);
        step(6'd31, '0);
        read_r("mul", exp_mul);

        // Repeated command gives the same result
        step(6'd31, '0);
        step(6'd31, '0);
        step(6'd26, '0);
        check("mul_repeat", eleOut, 32'd111);

        // No-op holds eleOut and R
        step(6'd40, 32'd5);
        check("noop_hold_out", eleOut, 32'd111);
        step(6'd18, '0);
        check("noop_keeps_r", eleOut, 32'd15);

        step(6'd32, 32'd2);
        read_r("scale", exp_2x);

        // Determinant of A = 0..8 is 0
        step(6'd33, '0);
        step(6'd27, '0);
        check("det_singular", eleOut, 32'd0);
        for (int i = 0; i < 9; i++) step(6'(i), DATA_W'(diag[i]));
        step(6'd33, '0);
        step(6'd27, '0);
        check("det_diag", eleOut, exp_det_diag);

        // Async reset mid-command clears eleOut immediately
        step(6'd19, '0);
        check("pre_reset_read", eleOut, 32'd2);
        sel = 6'd31;
        #2;
        reset = 1'b1;
        #1;
        check("async_reset_out", eleOut, 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        read_r("post_reset_r", exp_zero);
        step(6'd27, '0);
        check("post_reset_d", eleOut, 32'd0);
        step(6'd28, '0);
        step(6'd18, '0);
        check("post_reset_a", eleOut, 32'd0);

        // Wrap-around on add
        step(6'd0, 32'h7FFF_FFFF);
        step(6'd9, 32'h0000_0001);
        step(6'd29, '0);
        step(6'd18, '0);
        check("add_wrap", eleOut, 32'h8000_0000);

        // Wrap-around on subtract: 0 - 1
        step(6'd0, 32'd0);
        step(6'd30, '0);
        step(6'd18, '0);
        check("sub_wrap", eleOut, 32'hFFFF_FFFF);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Guard against a stalled run
    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/alu_matrix_top.md
ALU_MATRIX_TOP -- requirements
Module: alu_matrix_top

Interface
REQ-001 SHALL have parameter DATA_W, default 32: width of every matrix element, scalar and data port.
REQ-002 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset, input, 1 bit: reset, asynchronous and active-high.
REQ-004 SHALL have port sel, input, 6 bits: command and element selector, sampled each rising edge.
REQ-005 SHALL have port eleIn, input, DATA_W: write data for element loads; scalar operand for the scale command.
REQ-006 SHALL have port eleOut, output, DATA_W: registered read-back data.

Function
REQ-007 SHALL hold three 3x3 register matrices, indexed row-major 0..8 (index = 3*row + col): A (operand), B (operand), R (result); plus one scalar register D.
REQ-008 SHALL, for sel 0..8, write eleIn into A[sel] at the rising edge.
REQ-009 SHALL, for sel 9..17, write eleIn into B[sel-9] at the rising edge.
REQ-010 SHALL, for sel 18..26, load R[sel-18] into eleOut at the rising edge (1-cycle read latency).
REQ-011 SHALL, for sel 27, load D into eleOut at the rising edge.
REQ-012 SHALL execute the following commands in a single cycle; each writes all nine R elements at the rising edge:
- 28: transpose, R[i][j] = A[j][i].
- 29: add, R = A + B.
- 30: subtract, R = A - B.
- 31: multiply, R = A x B (matrix product).
- 32: scale, R = eleIn * A.
REQ-013 SHALL, for sel 33, compute the cofactor determinant of A into D: a(ei-fh) - b(di-fg) + c(dh-eg).
REQ-014 SHALL treat sel 34..63 as no-op: all state and eleOut hold.
REQ-015 SHALL hold eleOut unchanged on every edge where sel is not 18..27.
REQ-016 SHALL use two's-complement arithmetic with all results truncated to the low DATA_W bits (wrap-around, no saturation, no flags).
REQ-017 SHALL compute operations from register values present before the edge; a command held for several cycles re-executes with an identical result.
REQ-018 SHALL return the new R or D value on a read issued the cycle after the command.
REQ-019 SHALL have no handshake; one command per cycle, selected by the sel value alone.

Reset
REQ-020 SHALL asynchronously clear A, B, R, D and eleOut to 0 while reset is high, including when asserted mid-command.
REQ-021 SHALL ignore sel while reset is high; the first command executes on the first rising edge after deassertion.

Configuration
REQ-022 SHALL, when macro ALU_MATRIX_DET_EN is defined, implement command 33 per REQ-013.
REQ-023 SHALL, when ALU_MATRIX_DET_EN is undefined, treat sel 33 as a no-op, keep D at 0, and omit the determinant logic.

Structure
REQ-024 SHALL place DATA_W, the matrix dimension (3) and the named sel codes (LOAD_A_BASE=0, LOAD_B_BASE=9, READ_R_BASE=18, READ_D=27, TRANSPOSE=28, ADD=29, SUB=30, MUL=31, SCALE=32, DET=33) in a shared package alu_matrix_pkg.
REQ-025 SHALL implement the determinant as one combinational sub-module, matrix_det3 (nine elements in, one DATA_W result out).
REQ-026 SHALL instantiate matrix_det3 only under ALU_MATRIX_DET_EN.

Verification
REQ-027 SHALL cover load and transpose: reset, load A=B=0..8 via sel 0..17 (eleIn = index), sel 28, read sel 18..26 -> 0 3 6 / 1 4 7 / 2 5 8.
REQ-028 SHALL cover add and subtract: same operands; sel 29 -> 0 2 4 / 6 8 10 / 12 14 16; sel 30 -> all nine elements 0.
REQ-029 SHALL cover multiply: same operands; sel 31 -> 15 18 21 / 42 54 66 / 69 90 111.
REQ-030 SHALL cover scale and no-op: sel 40 then sel 32 with eleIn=2 -> 0 2 4 / 6 8 10 / 12 14 16; R unchanged by sel 40.
REQ-031 SHALL cover determinant: A=0..8, sel 33 then 27 -> 0; A = 2 0 0 / 0 3 0 / 0 0 4 -> 24; built without ALU_MATRIX_DET_EN -> 0.
REQ-032 SHALL cover reset and wrap: assert reset mid-sequence -> eleOut and all reads 0 immediately; A[0]=0x7FFFFFFF, B[0]=1, sel 29, read sel 18 -> 0x80000000.
